uart_tx_parity_framer: RTL and testbench

Parametrised UART transmit framer and serialiser.
- Accepts one DATA_W-bit word per handshake.
- Computes the parity bit in one of five run-time selectable modes.
- Shifts out start, data (LSB first), optional parity and 1 or 2 stop bits at CLKS_PER_BIT clocks per bit.
- Sits between the TX-side word source and the serial line pin.
- Successor to the fixed 8-bit even-parity generator: adds width, parity mode, stop-bit count and timing.

---
 rtl/uart_tx_parity_framer.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_parity_framer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_parity_framer.sv
// UART transmit framer: start bit, DATA_W data bits (LSB first), optional
// parity bit and one or two stop bits, each held CLKS_PER_BIT clocks.
// Every output is registered, so tx_out has no combinational path from inputs.
module uart_tx_parity_framer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              tx_start_in,
    input  logic [2:0]        parity_mode_in,
    input  logic              two_stop_in,
    output logic              tx_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              parity_bit_out
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   baud_cnt, baud_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [DATA_W-1:0]  shift_reg, shift_nxt;
    logic               par_en, par_en_nxt;
    logic               two_stop, two_stop_nxt;
    logic               tx_nxt, busy_nxt, done_nxt, parity_nxt;
    logic               baud_last;

    // Parity value for a word; modes 101-111 behave like "none" (0).
    function automatic logic calc_parity(input logic [DATA_W-1:0] d,
                                         input logic [2:0]        mode);
        case (mode)
            3'b001:  calc_parity = ^d;
            3'b010:  calc_parity = ~^d;
            3'b011:  calc_parity = 1'b1;
            default: calc_parity = 1'b0;
        endcase
    endfunction

    // A parity slot is only transmitted for even, odd, mark and space.
    function automatic logic parity_enabled(input logic [2:0] mode);
        parity_enabled = (mode >= 3'b001) && (mode <= 3'b100);
    endfunction

    assign baud_last = (baud_cnt == BAUD_LAST);

    // Next-state and next-output logic; bit timing advances on baud_last.
    always_comb begin
        state_nxt    = state_q;
        baud_nxt     = baud_cnt;
        bit_nxt      = bit_cnt;
        shift_nxt    = shift_reg;
        par_en_nxt   = par_en;
        two_stop_nxt = two_stop;
        parity_nxt   = parity_bit_out;
        tx_nxt       = tx_out;
        busy_nxt     = busy_out;
        done_nxt     = 1'b0;

        if (state_q != S_IDLE) begin
            baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (tx_start_in && !busy_out) begin
                    state_nxt    = S_START;
                    tx_nxt       = 1'b0;
                    busy_nxt     = 1'b1;
                    baud_nxt     = '0;
                    bit_nxt      = '0;
                    shift_nxt    = data_in;
                    par_en_nxt   = parity_enabled(parity_mode_in);
                    two_stop_nxt = two_stop_in;
                    parity_nxt   = calc_parity(data_in, parity_mode_in);
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_nxt = S_DATA;
                    tx_nxt    = shift_reg[0];
                    bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt = '0;
                        if (par_en) begin
                            state_nxt = S_PARITY;
                            tx_nxt    = parity_bit_out;
                        end else begin
                            state_nxt = S_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        shift_nxt = shift_reg >> 1;
                        tx_nxt    = shift_reg[1];
                        bit_nxt   = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                    bit_nxt   = '0;
                end
            end
            S_STOP: begin
                tx_nxt = 1'b1;
                if (baud_last) begin
                    if (two_stop && (bit_cnt == '0)) begin
                        bit_nxt = bit_cnt + 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        bit_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                baud_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops the frame and idles the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            baud_cnt       <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            par_en         <= 1'b0;
            two_stop       <= 1'b0;
            tx_out         <= 1'b1;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            parity_bit_out <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            baud_cnt       <= baud_nxt;
            bit_cnt        <= bit_nxt;
            shift_reg      <= shift_nxt;
            par_en         <= par_en_nxt;
            two_stop       <= two_stop_nxt;
            tx_out         <= tx_nxt;
            busy_out       <= busy_nxt;
            done_out       <= done_nxt;
            parity_bit_out <= parity_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_parity_framer.sv
// Bench for uart_tx_parity_framer with DATA_W=8, CLKS_PER_BIT=4.
// Expected line bits are queued when a frame is requested and popped as the
// DUT shifts them out; outputs are sampled on the falling clock edge.
module tb_uart_tx_parity_framer;
    localparam int DATA_W = 8;
    localparam int CPB    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              tx_start_in = 1'b0;
    logic [2:0]        parity_mode_in = 3'd0;
    logic              two_stop_in = 1'b0;
    logic              tx_out, busy_out, done_out, parity_bit_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];
    bit par_q[$];

    always #5 clk = ~clk;

    uart_tx_parity_framer #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .tx_start_in(tx_start_in),
        .parity_mode_in(parity_mode_in), .two_stop_in(two_stop_in),
        .tx_out(tx_out), .busy_out(busy_out), .done_out(done_out),
        .parity_bit_out(parity_bit_out)
    );

    function automatic bit model_parity(input logic [7:0] d, input logic [2:0] m);
        case (m)
            3'd1:    return ^d;
            3'd2:    return ~^d;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit parity_on(input logic [2:0] m);
        return (m >= 3'd1) && (m <= 3'd4);
    endfunction

    function automatic int frame_bits(input logic [2:0] m, input bit two);
        return 1 + DATA_W + (parity_on(m) ? 1 : 0) + (two ? 2 : 1);
    endfunction

    // Scoreboard producer: expected line bits and parity for one frame.
    task automatic push_frame(input logic [7:0] d, input logic [2:0] m, input bit two);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) exp_q.push_back(d[i]);
        if (parity_on(m)) exp_q.push_back(model_parity(d, m));
        exp_q.push_back(1'b1);
        if (two) exp_q.push_back(1'b1);
        par_q.push_back(model_parity(d, m));
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (tx_out !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx_out); else n_pass++;
        n_checks++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_out); else n_pass++;
        n_checks++; if (done_out !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_out); else n_pass++;
        n_checks++; if (parity_bit_out !== 1'b0) $display("FAIL reset_parity: got %b expected 0", parity_bit_out); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (tx_out !== 1'b1) $display("FAIL idle_tx: got %b expected 1", tx_out); else n_pass++;
    endtask

    // Single frames: 0x55 even, 0x80 odd 2-stop, 0xA3 none/mark/space.
    task automatic test_frames();
        logic [7:0] d_t[5] = '{8'h55, 8'h80, 8'hA3, 8'hA3, 8'hA3};
        logic [2:0] m_t[5] = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd4};
        bit         s_t[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int f = 0; f < 5; f++) begin
            int nb, busy_cnt, done_cnt;
            bit cur, exp_par;
            nb = frame_bits(m_t[f], s_t[f]);
            busy_cnt = 0; done_cnt = 0; cur = 1'b1;
            data_in = d_t[f]; parity_mode_in = m_t[f]; two_stop_in = s_t[f];
            tx_start_in = 1'b1;
            push_frame(d_t[f], m_t[f], s_t[f]);
            @(negedge clk);
            tx_start_in = 1'b0;
            for (int j = 0; j < nb * CPB; j++) begin
                if (j % CPB == 0) cur = exp_q.pop_front();
                n_checks++;
                if (tx_out !== cur) $display("FAIL frame%0d_tx cyc %0d: got %b expected %b", f, j, tx_out, cur);
                else n_pass++;
                if (busy_out) busy_cnt++;
                if (done_out) done_cnt++;
                @(negedge clk);
            end
            exp_par = par_q.pop_front();
            n_checks++; if (done_out !== 1'b1) $display("FAIL frame%0d_done: got %b expected 1", f, done_out); else n_pass++;
            n_checks++; if (busy_out !== 1'b0) $display("FAIL frame%0d_busy_end: got %b expected 0", f, busy_out); else n_pass++;
            n_checks++; if (busy_cnt !== nb * CPB) $display("FAIL frame%0d_busy_cycles: got %0d expected %0d", f, busy_cnt, nb * CPB); else n_pass++;
            n_checks++; if (done_cnt !== 0) $display("FAIL frame%0d_early_done: got %0d expected 0", f, done_cnt); else n_pass++;
            n_checks++; if (parity_bit_out !== exp_par) $display("FAIL frame%0d_parity: got %b expected %b", f, parity_bit_out, exp_par); else n_pass++;
            @(negedge clk);
            n_checks++; if (done_out !== 1'b0) $display("FAIL frame%0d_done_width: got %b expected 0", f, done_out); else n_pass++;
            n_checks++; if (tx_out !== 1'b1) $display("FAIL frame%0d_idle: got %b expected 1", f, tx_out); else n_pass++;
        end
    endtask

    // tx_start_in held high: 0x0F then 0xF0 with one idle cycle between.
    task automatic test_back_to_back();
        int nb;
        bit cur;
        nb = frame_bits(3'd1, 1'b0);
        cur = 1'b1;
        data_in = 8'h0F; parity_mode_in = 3'd1; two_stop_in = 1'b0;
        tx_start_in = 1'b1;
        push_frame(8'h0F, 3'd1, 1'b0);
        push_frame(8'hF0, 3'd1, 1'b0);
        @(negedge clk);
        data_in = 8'hF0;
        for (int f = 0; f < 2; f++) begin
            bit exp_par;
            for (int j = 0; j < nb * CPB; j++) begin
                if (j % CPB == 0) cur = exp_q.pop_front();
                n_checks++;
                if (tx_out !== cur) $display("FAIL b2b%0d_tx cyc %0d: got %b expected %b", f, j, tx_out, cur);
                else n_pass++;
                if (f == 1 && j == 0) tx_start_in = 1'b0;
                @(negedge clk);
            end
            exp_par = par_q.pop_front();
            n_checks++; if (done_out !== 1'b1) $display("FAIL b2b%0d_done: got %b expected 1", f, done_out); else n_pass++;
            n_checks++; if (busy_out !== 1'b0) $display("FAIL b2b%0d_busy: got %b expected 0", f, busy_out); else n_pass++;
            n_checks++; if (parity_bit_out !== exp_par) $display("FAIL b2b%0d_parity: got %b expected %b", f, parity_bit_out, exp_par); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (done_out !== 1'b0 || busy_out !== 1'b0) $display("FAIL b2b_final_idle: got done=%b busy=%b expected 0 0", done_out, busy_out); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL b2b_queue: got %0d left expected 0", exp_q.size()); else n_pass++;
    endtask

    // Start pulses and input changes during busy must not disturb the frame.
    task automatic test_ignore_busy();
        int nb, done_cnt;
        bit cur, exp_par;
        nb = frame_bits(3'd2, 1'b1);
        done_cnt = 0; cur = 1'b1;
        data_in = 8'hC5; parity_mode_in = 3'd2; two_stop_in = 1'b1;
        tx_start_in = 1'b1;
        push_frame(8'hC5, 3'd2, 1'b1);
        @(negedge clk);
        tx_start_in = 1'b0;
        for (int j = 0; j < nb * CPB; j++) begin
            if (j % CPB == 0) cur = exp_q.pop_front();
            n_checks++;
            if (tx_out !== cur) $display("FAIL busy_tx cyc %0d: got %b expected %b", j, tx_out, cur);
            else n_pass++;
            if (done_out) done_cnt++;
            if (j == 5 || j == 13 || j == 20 || j == 37) begin
                tx_start_in = 1'b1;
                data_in = DATA_W'($urandom);
                parity_mode_in = 3'($urandom_range(0, 7));
                two_stop_in = ~two_stop_in;
            end else begin
                tx_start_in = 1'b0;
            end
            @(negedge clk);
        end
        exp_par = par_q.pop_front();
        n_checks++; if (parity_bit_out !== exp_par) $display("FAIL busy_parity: got %b expected %b", parity_bit_out, exp_par); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (done_out) done_cnt++;
            @(negedge clk);
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL busy_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (busy_out !== 1'b0) $display("FAIL busy_no_restart: got %b expected 0", busy_out); else n_pass++;
    endtask

    // Reset at cycle 17 abandons the frame; a fresh 0x3C frame follows.
    task automatic test_reset_mid_frame();
        int nb, done_cnt;
        bit cur, exp_par;
        cur = 1'b1; done_cnt = 0;
        data_in = 8'hF3; parity_mode_in = 3'd2; two_stop_in = 1'b0;
        tx_start_in = 1'b1;
        push_frame(8'hF3, 3'd2, 1'b0);
        @(negedge clk);
        tx_start_in = 1'b0;
        for (int j = 0; j < 17; j++) begin
            if (j % CPB == 0) cur = exp_q.pop_front();
            @(negedge clk);
        end
        n_checks++; if (tx_out !== 1'b0) $display("FAIL rst_pre_tx: got %b expected 0", tx_out); else n_pass++;
        n_checks++; if (parity_bit_out !== 1'b1) $display("FAIL rst_pre_parity: got %b expected 1", parity_bit_out); else n_pass++;
        exp_q.delete();
        par_q.delete();
        rst_n = 1'b0;
        #1;
        n_checks++; if (tx_out !== 1'b1) $display("FAIL rst_async_tx: got %b expected 1", tx_out); else n_pass++;
        n_checks++; if (busy_out !== 1'b0) $display("FAIL rst_async_busy: got %b expected 0", busy_out); else n_pass++;
        n_checks++; if (parity_bit_out !== 1'b0) $display("FAIL rst_async_parity: got %b expected 0", parity_bit_out); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_out) done_cnt++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done_out) done_cnt++;
        end
        n_checks++; if (done_cnt !== 0) $display("FAIL rst_no_done: got %0d expected 0", done_cnt); else n_pass++;
        nb = frame_bits(3'd2, 1'b0);
        data_in = 8'h3C; parity_mode_in = 3'd2; two_stop_in = 1'b0;
        tx_start_in = 1'b1;
        push_frame(8'h3C, 3'd2, 1'b0);
        @(negedge clk);
        tx_start_in = 1'b0;
        for (int j = 0; j < nb * CPB; j++) begin
            if (j % CPB == 0) cur = exp_q.pop_front();
            n_checks++;
            if (tx_out !== cur) $display("FAIL post_rst_tx cyc %0d: got %b expected %b", j, tx_out, cur);
            else n_pass++;
            @(negedge clk);
        end
        exp_par = par_q.pop_front();
        n_checks++; if (done_out !== 1'b1) $display("FAIL post_rst_done: got %b expected 1", done_out); else n_pass++;
        n_checks++; if (parity_bit_out !== exp_par) $display("FAIL post_rst_parity: got %b expected %b", parity_bit_out, exp_par); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
